// File: rtl/grid_loader.sv
// grid_loader: framed serial seed writer for the 8x8 Game of Life grid.
// Rows are collected in a shadow buffer and reach seed only after the checksum verifies.
module grid_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd255
) (
    input  logic        clk,
    input  logic        _rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] seed,
    output logic        load,
    input  logic        load_ack,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a byte moves on a rising edge where in_valid & in_ready are both high,
    // and in_data is only looked at on such an edge. load stays high until an edge with load_ack.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROWS   = 2'd1,
        S_CHECK  = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  row_cnt_q, row_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  xor_q, xor_d;
    logic [63:0] shadow_q, shadow_d;
    logic [63:0] seed_q, seed_d;
    logic        load_q, load_d;
    logic        err_q, err_d;
    logic        xfer;
    logic        timeout_hit;

    assign in_ready  = _rst && (state_q != S_COMMIT);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;
    assign seed      = seed_q;
    assign load      = load_q;
    assign err       = err_q;

    assign xfer = in_valid && in_ready;

    // Aborts on the TIMEOUT-th consecutive idle edge; a transfer on that edge wins.
    assign timeout_hit = (TIMEOUT != 16'd0) && (timer_q == TIMEOUT - 16'd1) && !xfer;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        timer_d   = timer_q;
        xor_d     = xor_q;
        shadow_d  = shadow_q;
        seed_d    = seed_q;
        load_d    = load_q;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = 16'd0;
                if (xfer && (in_data == SYNC_BYTE)) begin
                    state_d   = S_ROWS;
                    row_cnt_d = 3'd0;
                    xor_d     = 8'd0;
                end
            end

            S_ROWS: begin
                if (xfer) begin
                    // Byte MSB is column 0 of the row.
                    for (int c = 0; c < 8; c++) begin
                        shadow_d[{row_cnt_q, 3'(c)}] = in_data[3'(7 - c)];
                    end
                    xor_d     = xor_q ^ in_data;
                    timer_d   = 16'd0;
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == 3'd7) begin
                        state_d = S_CHECK;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    timer_d = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            S_CHECK: begin
                if (xfer) begin
                    timer_d = 16'd0;
                    if (in_data == xor_q) begin
                        seed_d  = shadow_q;
                        load_d  = 1'b1;
                        state_d = S_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    timer_d = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            S_COMMIT: begin
                if (load_ack) begin
                    load_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            state_q   <= S_IDLE;
            row_cnt_q <= 3'd0;
            timer_q   <= 16'd0;
            xor_q     <= 8'd0;
            shadow_q  <= 64'd0;
            seed_q    <= 64'd0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            timer_q   <= timer_d;
            xor_q     <= xor_d;
            shadow_q  <= shadow_d;
            seed_q    <= seed_d;
            load_q    <= load_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_grid_loader.sv
// Bench for grid_loader: directed scenarios plus random frames checked against a
// frame-level model (seed from row bytes, XOR checksum, idle-gap abort).
module tb_grid_loader;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        _rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] seed;
    logic        load;
    logic        load_ack;
    logic        err;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] model_seed = 64'd0;

    logic [7:0] f_rows[8];
    logic [7:0] f_cks;
    int         f_gap[10];

    int          err_cnt       = 0;
    int          load_rise_cnt = 0;
    logic        load_prev     = 1'b0;
    logic [63:0] cap_seed      = 64'd0;

    grid_loader #(
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (16'(TB_TIMEOUT))
    ) dut (
        .clk       (clk),
        ._rst      (_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seed      (seed),
        .load      (load),
        .load_ack  (load_ack),
        .err       (err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and reset-free watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Event monitor on the falling edge: counts err-high cycles and load rises.
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (load === 1'b1 && load_prev !== 1'b1) begin
            load_rise_cnt++;
            cap_seed = seed;
        end
        load_prev = load;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: idle for gap edges, then present b until it is taken.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chkb("ready_wait", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] g;
        for (int k = 0; k < n; k++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send(g, $urandom_range(0, 2));
        end
    endtask

    function automatic logic [63:0] pack_rows();
        logic [63:0] s;
        s = 64'd0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                s[8 * r + c] = f_rows[r][7 - c];
        return s;
    endfunction

    function automatic logic [7:0] frame_byte(input int i);
        if (i == 0) return 8'hA5;
        if (i == 9) return f_cks;
        return f_rows[i - 1];
    endfunction

    task automatic set_glider(input logic [7:0] cks);
        f_rows = '{8'h40, 8'h20, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        f_cks  = cks;
        for (int i = 0; i < 10; i++) f_gap[i] = 0;
    endtask

    task automatic rand_frame(input bit allow_bad);
        logic [7:0] x;
        x = 8'd0;
        for (int r = 0; r < 8; r++) f_rows[r] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) f_rows[$urandom_range(0, 7)] = 8'hA5;
        for (int r = 0; r < 8; r++) x ^= f_rows[r];
        f_cks = x;
        if (allow_bad && $urandom_range(0, 3) == 0) f_cks = x ^ 8'($urandom_range(1, 255));
        f_gap[0] = $urandom_range(0, 3);
        for (int i = 1; i < 10; i++) begin
            if (allow_bad && $urandom_range(0, 29) == 0) f_gap[i] = $urandom_range(TB_TIMEOUT, TB_TIMEOUT + 2);
            else f_gap[i] = $urandom_range(0, TB_TIMEOUT - 1);
        end
    endtask

    // Entered the cycle after the checksum edge with load expected high.
    task automatic do_commit(input int d, input bit hold);
        int hi;
        hi = 0;
        if (hold) begin
            in_valid = 1'b1;
            in_data  = 8'hA5;
        end
        for (int i = 0; i < d; i++) begin
            if (load === 1'b1) hi++;
            chkb("ready_in_commit", in_ready, 1'b0);
            tick();
        end
        load_ack = 1'b1;
        if (load === 1'b1) hi++;
        chkb("ready_at_ack", in_ready, 1'b0);
        tick();
        load_ack = 1'b0;
        in_valid = 1'b0;
        chk("load_cycles", 64'(hi), 64'(d + 1));
        chkb("load_dropped", load, 1'b0);
    endtask

    task automatic run_frame(input int d, input bit hold);
        int          e0;
        int          l0;
        logic [7:0]  x;
        logic [63:0] exp_seed;
        bit          aborted;
        e0 = err_cnt;
        l0 = load_rise_cnt;
        x = 8'd0;
        aborted = 1'b0;
        for (int r = 0; r < 8; r++) x ^= f_rows[r];
        exp_seed = pack_rows();
        for (int i = 0; i < 10; i++) begin
            if (!aborted) begin
                if (i > 0 && f_gap[i] >= TB_TIMEOUT) begin
                    in_valid = 1'b0;
                    repeat (f_gap[i]) tick();
                    aborted = 1'b1;
                end else begin
                    send(frame_byte(i), f_gap[i]);
                end
            end
        end
        if (!aborted && f_cks == x) begin
            exp_q.push_back(exp_seed);
            chkb("load_after_cks", load, 1'b1);
            chk("seed_at_load", seed, exp_seed);
            do_commit(d, hold);
            model_seed = exp_q.pop_front();
            tick();
            chk("load_rises", 64'(load_rise_cnt - l0), 64'd1);
            chk("seed_captured", cap_seed, model_seed);
            chk("err_none", 64'(err_cnt - e0), 64'd0);
        end else begin
            tick();
            tick();
            chk("err_pulses", 64'(err_cnt - e0), 64'd1);
            chk("load_none", 64'(load_rise_cnt - l0), 64'd0);
        end
        chk("seed_kept", seed, model_seed);
        chkb("busy_idle", busy, 1'b0);
    endtask

    initial begin
        int e0;
        int l0;
        logic [7:0] x;
        _rst     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        load_ack = 1'b0;
        repeat (3) begin
            tick();
            chkb("ready_in_reset", in_ready, 1'b0);
        end
        chk("seed_reset", seed, 64'd0);
        chkb("load_reset", load, 1'b0);
        chkb("err_reset", err, 1'b0);
        chkb("busy_reset", busy, 1'b0);
        _rst = 1'b1;
        tick();
        chkb("ready_after_reset", in_ready, 1'b1);

        // Bad checksum first: seed must stay zero, then the good glider loads.
        set_glider(8'h81);
        run_frame(0, 1'b0);
        set_glider(8'h80);
        run_frame(2, 1'b0);
        chk("glider_const", seed, 64'h0000_0000_0007_0402);

        // Leading garbage is dropped.
        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'h13, 0);
        set_glider(8'h80);
        run_frame(1, 1'b0);
        chk("glider_after_garbage", seed, 64'h0000_0000_0007_0402);

        // Timeout after A5,40 followed by four idle cycles, then a full frame.
        set_glider(8'h80);
        f_gap[2] = TB_TIMEOUT;
        run_frame(0, 1'b0);
        rand_frame(1'b0);
        run_frame(0, 1'b0);

        // Long COMMIT dwell with the stream trying to push bytes.
        rand_frame(1'b0);
        run_frame(20, 1'b1);

        // Reset after three rows following a committed frame.
        do begin
            rand_frame(1'b0);
            x = f_cks;
        end while (x == 8'hA5 || f_rows[3] == 8'hA5 || f_rows[4] == 8'hA5 ||
                   f_rows[5] == 8'hA5 || f_rows[6] == 8'hA5 || f_rows[7] == 8'hA5);
        run_frame(0, 1'b0);
        send(8'hA5, 0);
        for (int r = 0; r < 3; r++) send(f_rows[r], 0);
        _rst = 1'b0;
        tick();
        chkb("ready_low_mid_reset", in_ready, 1'b0);
        _rst = 1'b1;
        chk("seed_cleared", seed, 64'd0);
        chkb("load_cleared", load, 1'b0);
        chkb("busy_cleared", busy, 1'b0);
        model_seed = 64'd0;
        e0 = err_cnt;
        l0 = load_rise_cnt;
        for (int r = 3; r < 8; r++) send(f_rows[r], 0);
        send(f_cks, 0);
        tick();
        tick();
        chk("tail_no_err", 64'(err_cnt - e0), 64'd0);
        chk("tail_no_load", 64'(load_rise_cnt - l0), 64'd0);
        chk("tail_seed", seed, 64'd0);
        chkb("tail_busy", busy, 1'b0);
        rand_frame(1'b0);
        run_frame($urandom_range(0, 3), 1'b0);

        // Random frames: garbage, bad checksums, timeouts, A5 as row data.
        for (int k = 0; k < 40; k++) begin
            send_garbage($urandom_range(0, 3));
            rand_frame(1'b1);
            run_frame($urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
